// File: rtl/mor1kx_ticktimer_multi.sv
// Multi-channel tick timer on the SPR group 10 slot.
// NUM_CH independent TTMR/TTCR pairs, a shared W1C pending register (TTSR),
// per-channel IRQ lines and a debug freeze input.
// Optional shared prescaler enabled by defining MOR1KX_TTIMER_PRESCALE_EN;
// without it every channel behaves exactly like the legacy single tick timer.
module mor1kx_ticktimer_multi #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_WIDTH      = 28,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spr_access_i,
    input  logic              spr_we_i,
    input  logic [15:0]       spr_addr_i,
    input  logic [31:0]       spr_dat_i,
    output logic              spr_bus_ack,
    output logic [31:0]       spr_dat_o,
    input  logic              du_stall_i,
    output logic [NUM_CH-1:0] irq_o,
    output logic              irq_any_o
);

    logic [10:0] offset;
    logic        spr_wr;
    logic        ttsr_we;
    logic        ttpr_we;
    logic        tick;
    logic        prescale_hit;
    logic [31:0] ttpr_rdata;

    logic [NUM_CH-1:0][1:0]           mode_q, mode_d;
    logic [NUM_CH-1:0]                ie_q, ie_d;
    logic [NUM_CH-1:0]                ip_q, ip_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] period_q, period_d;
    logic [NUM_CH-1:0][31:0]          ttcr_q, ttcr_d;
    logic [NUM_CH-1:0]                ttmr_we, ttcr_we, match;

    // Upper address bits select the SPR group and are decoded outside.
    logic unused_addr;
    assign unused_addr = ^spr_addr_i[15:11];

    assign offset      = spr_addr_i[10:0];
    assign spr_wr      = spr_access_i & spr_we_i;
    assign ttsr_we     = spr_wr && (offset == 11'h000);
    assign ttpr_we     = spr_wr && (offset == 11'h001);
    assign spr_bus_ack = spr_access_i;
    assign tick        = ~du_stall_i & prescale_hit;
    assign irq_o       = ip_q;
    assign irq_any_o   = |ip_q;

`ifdef MOR1KX_TTIMER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] ttpr_q, ttpr_d, pc_q, pc_d;

    assign prescale_hit = (pc_q == ttpr_q);
    assign ttpr_rdata   = 32'(ttpr_q);

    // Prescale counter wraps on hit; a TTPR write restarts it.
    always_comb begin
        ttpr_d = ttpr_q;
        pc_d   = pc_q;
        if (!du_stall_i) begin
            pc_d = prescale_hit ? '0 : pc_q + 1'b1;
        end
        if (ttpr_we) begin
            ttpr_d = spr_dat_i[PRESCALE_WIDTH-1:0];
            pc_d   = '0;
        end
    end

    // Prescaler state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ttpr_q <= '0;
            pc_q   <= '0;
        end else begin
            ttpr_q <= ttpr_d;
            pc_q   <= pc_d;
        end
    end
`else
    logic [PRESCALE_WIDTH-1:0] unused_ttpr;
    logic                      unused_ttpr_we;
    assign unused_ttpr    = spr_dat_i[PRESCALE_WIDTH-1:0];
    assign unused_ttpr_we = ttpr_we;
    assign prescale_hit   = 1'b1;
    assign ttpr_rdata     = '0;
`endif

    // Per-channel address decode and period match.
    always_comb begin
        ttmr_we = '0;
        ttcr_we = '0;
        match   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ttmr_we[i] = spr_wr && (offset == 11'(16 + 2 * i));
            ttcr_we[i] = spr_wr && (offset == 11'(17 + 2 * i));
            match[i]   = (ttcr_q[i][CNT_WIDTH-1:0] == period_q[i]);
        end
    end

    // Channel next state; SPR writes are applied last so they win.
    always_comb begin
        mode_d   = mode_q;
        ie_d     = ie_q;
        ip_d     = ip_q;
        period_d = period_q;
        ttcr_d   = ttcr_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick) begin
                case (mode_q[i])
                    2'b01:   ttcr_d[i] = match[i] ? 32'h0 : ttcr_q[i] + 32'h1;
                    2'b10:   if (!match[i]) ttcr_d[i] = ttcr_q[i] + 32'h1;
                    2'b11:   ttcr_d[i] = ttcr_q[i] + 32'h1;
                    default: ;
                endcase
            end
            if (ttcr_we[i]) begin
                ttcr_d[i] = spr_dat_i;
            end
            // W1C first so a coincident match keeps the interrupt.
            if (ttsr_we && spr_dat_i[i]) begin
                ip_d[i] = 1'b0;
            end
            if (tick && match[i] && ie_q[i]) begin
                ip_d[i] = 1'b1;
            end
            if (ttmr_we[i]) begin
                mode_d[i]   = spr_dat_i[31:30];
                ie_d[i]     = spr_dat_i[29];
                ip_d[i]     = spr_dat_i[28];
                period_d[i] = spr_dat_i[CNT_WIDTH-1:0];
            end
        end
    end

    // Channel register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= '0;
            ie_q     <= '0;
            ip_q     <= '0;
            period_q <= '0;
            ttcr_q   <= '0;
        end else begin
            mode_q   <= mode_d;
            ie_q     <= ie_d;
            ip_q     <= ip_d;
            period_q <= period_d;
            ttcr_q   <= ttcr_d;
        end
    end

    // Combinational read mux returning pre-update register values.
    always_comb begin
        spr_dat_o = '0;
        if (spr_access_i) begin
            if (offset == 11'h000) begin
                spr_dat_o = 32'(ip_q);
            end else if (offset == 11'h001) begin
                spr_dat_o = ttpr_rdata;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (offset == 11'(16 + 2 * i)) begin
                    spr_dat_o[31:30]          = mode_q[i];
                    spr_dat_o[29]             = ie_q[i];
                    spr_dat_o[28]             = ip_q[i];
                    spr_dat_o[CNT_WIDTH-1:0]  = period_q[i];
                end else if (offset == 11'(17 + 2 * i)) begin
                    spr_dat_o = ttcr_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_ticktimer_multi.sv
// Directed bench for mor1kx_ticktimer_multi with a scoreboard queue.
// Expectations for the prescaler step follow MOR1KX_TTIMER_PRESCALE_EN.
module tb_mor1kx_ticktimer_multi;

    localparam int unsigned NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              spr_access_i;
    logic              spr_we_i;
    logic [15:0]       spr_addr_i;
    logic [31:0]       spr_dat_i;
    logic              spr_bus_ack;
    logic [31:0]       spr_dat_o;
    logic              du_stall_i;
    logic [NUM_CH-1:0] irq_o;
    logic              irq_any_o;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    mor1kx_ticktimer_multi #(
        .NUM_CH         (NUM_CH),
        .CNT_WIDTH      (28),
        .PRESCALE_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spr_access_i (spr_access_i),
        .spr_we_i     (spr_we_i),
        .spr_addr_i   (spr_addr_i),
        .spr_dat_i    (spr_dat_i),
        .spr_bus_ack  (spr_bus_ack),
        .spr_dat_o    (spr_dat_o),
        .du_stall_i   (du_stall_i),
        .irq_o        (irq_o),
        .irq_any_o    (irq_any_o)
    );

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic spr_wr(input logic [10:0] off, input logic [31:0] dat);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b1;
        spr_addr_i   = {5'b0, off};
        spr_dat_i    = dat;
        @(negedge clk);
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
        spr_dat_i    = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [10:0] off, input logic [31:0] exp);
        sb_push(tag, exp);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b0;
        spr_addr_i   = {5'b0, off};
        #1;
        sb_check(spr_dat_o);
        @(negedge clk);
        spr_access_i = 1'b0;
    endtask

    task automatic irq_chk(input string tag, input logic [NUM_CH-1:0] exp);
        sb_push(tag, 32'({|exp, exp}));
        sb_check(32'({irq_any_o, irq_o}));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
        spr_addr_i   = '0;
        spr_dat_i    = '0;
        du_stall_i   = 1'b0;
        tick(2);

        // Reset state and idle bus
        irq_chk("rst_irq", 4'b0000);
        sb_push("idle_dat", 32'h0);
        sb_check(spr_dat_o);
        sb_push("idle_ack", 32'h0);
        sb_check(32'(spr_bus_ack));
        rst = 1'b0;
        spr_access_i = 1'b1;
        spr_addr_i   = 16'h0011;
        #1;
        sb_push("ack_on_access", 32'h1);
        sb_check(32'(spr_bus_ack));
        spr_access_i = 1'b0;
        @(negedge clk);
        rd_chk("rst_ttmr0", 11'h010, 32'h0);
        rd_chk("rst_ttcr0", 11'h011, 32'h0);
        rd_chk("rst_ttsr", 11'h000, 32'h0);

        // 1) restart mode, period 5, with IE
        spr_wr(11'h010, 32'h6000_0005);
        spr_wr(11'h011, 32'h0);
        for (int k = 0; k < 8; k++) begin
            irq_chk($sformatf("t1_irq_%0d", k), (k >= 6) ? 4'b0001 : 4'b0000);
            rd_chk($sformatf("t1_ttcr0_%0d", k), 11'h011, 32'(k % 6));
        end
        rd_chk("t1_ttmr0_ip", 11'h010, 32'h7000_0005);

        // 2) stop mode on ch1, W1C under freeze
        spr_wr(11'h012, 32'hA000_0003);
        spr_wr(11'h013, 32'h0);
        tick(6);
        rd_chk("t2_ttcr1_stop", 11'h013, 32'h3);
        irq_chk("t2_irq_set", 4'b0011);
        du_stall_i = 1'b1;
        spr_wr(11'h000, 32'h2);
        irq_chk("t2_w1c_ch1", 4'b0001);
        rd_chk("t2_ttcr1_held", 11'h013, 32'h3);
        du_stall_i = 1'b0;
        tick(1);
        irq_chk("t2_ch1_relevel", 4'b0011);

        // 3) continuous mode wraps through zero
        spr_wr(11'h014, 32'hC000_0000);
        spr_wr(11'h015, 32'hFFFF_FFFE);
        rd_chk("t3_wrap_0", 11'h015, 32'hFFFF_FFFE);
        rd_chk("t3_wrap_1", 11'h015, 32'hFFFF_FFFF);
        rd_chk("t3_wrap_2", 11'h015, 32'h0000_0000);
        rd_chk("t3_wrap_3", 11'h015, 32'h0000_0001);
        irq_chk("t3_no_ie", 4'b0011);

        // 4) W1C vs set, TTCR write on match, TTMR clear of IP
        spr_wr(11'h011, 32'h3);
        spr_wr(11'h000, 32'h1);
        irq_chk("t4_w1c_ch0", 4'b0010);
        tick(1);
        spr_wr(11'h000, 32'h1);
        irq_chk("t4_set_beats_w1c", 4'b0011);
        tick(5);
        spr_wr(11'h011, 32'h100);
        rd_chk("t4_write_beats_restart", 11'h011, 32'h100);
        spr_wr(11'h010, 32'h6000_0005);
        irq_chk("t4_ttmr_clear", 4'b0010);

        // 5) debug freeze, then reset mid-count
        spr_wr(11'h015, 32'h40);
        du_stall_i = 1'b1;
        tick(10);
        rd_chk("t5_frozen_ttcr0", 11'h011, 32'h103);
        rd_chk("t5_frozen_ttcr2", 11'h015, 32'h40);
        du_stall_i = 1'b0;
        rd_chk("t5_resume_0", 11'h011, 32'h103);
        rd_chk("t5_resume_1", 11'h011, 32'h104);
        rd_chk("t5_resume_ttcr2", 11'h015, 32'h42);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        irq_chk("t5_rst_irq", 4'b0000);
        rd_chk("t5_rst_ttcr0", 11'h011, 32'h0);
        rd_chk("t5_rst_ttmr0", 11'h010, 32'h0);
        rd_chk("t5_rst_ttcr2", 11'h015, 32'h0);
        rd_chk("t5_rst_ttmr1", 11'h012, 32'h0);
        rd_chk("t5_rst_ttsr", 11'h000, 32'h0);
        rd_chk("unmapped_018", 11'h018, 32'h0);
        rd_chk("unmapped_7ff", 11'h7FF, 32'h0);

        // 6) prescaler
        spr_wr(11'h001, 32'h3);
`ifdef MOR1KX_TTIMER_PRESCALE_EN
        rd_chk("t6_ttpr", 11'h001, 32'h3);
`else
        rd_chk("t6_ttpr", 11'h001, 32'h0);
`endif
        spr_wr(11'h010, 32'hC000_0000);
        spr_wr(11'h011, 32'h0);
        for (int k = 0; k < 9; k++) begin
`ifdef MOR1KX_TTIMER_PRESCALE_EN
            rd_chk($sformatf("t6_ttcr0_%0d", k), 11'h011, 32'((k + 3) / 4));
`else
            rd_chk($sformatf("t6_ttcr0_%0d", k), 11'h011, 32'(k));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
